imem_fetch_unit: RTL and testbench

Parametrised instruction memory for the 32-bit processor. It replaces the hard-coded program image with a loader write port, so a testbench or boot loader writes the program after reset. Fetch uses a one-cycle request/valid handshake with stall hold. Out-of-range PCs are detected and return a NOP.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_ram_array.sv | 49 ++++
 rtl/imem_fetch_unit.sv | 88 ++++++++
 tb/tb_imem_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction memory and its neighbours.
// Decode and PC blocks pick up the same word/address widths from here.
package imem_pkg;

   typedef enum logic {
      ST_LOAD,
      ST_RUN
   } imem_state_e;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 10;
   localparam int DEPTH_DEF  = 256;

   // ADD R0,R0,R0
   localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

endpackage

// File: rtl/imem_ram_array.sv
// Single-port synchronous instruction RAM with registered read.
// IMEM_PARITY_EN adds an even-parity column checked on every read.
module imem_ram_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata,
   output logic              rpar_err
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Program image write; contents are never cleared by reset
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read port; holds its value when no read is enabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

`ifdef IMEM_PARITY_EN
   logic [DEPTH-1:0] par;

   // Parity column written alongside each word
   always_ff @(posedge clk) begin
      if (we) par[waddr] <= ^wdata;
   end

   // Recompute parity on read and flag a mismatch with the data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rpar_err <= 1'b0;
      else if (re) rpar_err <= (^mem[raddr]) ^ par[raddr];
   end
`else
   assign rpar_err = 1'b0;
`endif

endmodule

// File: rtl/imem_fetch_unit.sv
// Loadable instruction memory with request/valid fetch and stall hold.
// Optional parity checking is enabled by defining IMEM_PARITY_EN.
module imem_fetch_unit
   import imem_pkg::*;
#(
   parameter int                DATA_W   = DATA_W_DEF,
   parameter int                DEPTH    = DEPTH_DEF,
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_done,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] pc,
   input  logic              stall,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              addr_err,
   output logic              load_err,
   output logic              running,
   output logic              parity_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

   imem_state_e       state;
   logic              ld_in_rng;
   logic              pc_in_rng;
   logic              ram_we;
   logic              ram_re;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_perr;

   assign ld_in_rng = {1'b0, ld_addr} < DEPTH_A;
   assign pc_in_rng = {1'b0, pc} < DEPTH_A;

   assign ram_we = (state == ST_LOAD) && ld_we && ld_in_rng;
   assign ram_re = (state == ST_RUN) && fetch_req && !stall && pc_in_rng;

   imem_ram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_ram (
      .clk      (clk),
      .reset    (reset),
      .we       (ram_we),
      .waddr    (ld_addr[IDX_W-1:0]),
      .wdata    (ld_data),
      .re       (ram_re),
      .raddr    (pc[IDX_W-1:0]),
      .rdata    (ram_rdata),
      .rpar_err (ram_perr)
   );

   // Load/run sequencing, fetch handshake with stall hold, error flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_LOAD;
         instr_valid <= 1'b0;
         addr_err    <= 1'b0;
         load_err    <= 1'b0;
      end else begin
         unique case (state)
            ST_LOAD: if (ld_done) state <= ST_RUN;
            ST_RUN:  state <= ST_RUN;
            default: state <= ST_LOAD;
         endcase
         if (ld_we && ((state == ST_RUN) || !ld_in_rng))
            load_err <= 1'b1;
         if ((state == ST_RUN) && !stall) begin
            instr_valid <= fetch_req;
            if (fetch_req) addr_err <= !pc_in_rng;
         end
      end
   end

   // Out-of-range results substitute the NOP for the stale RAM word
   assign instr      = addr_err ? NOP_WORD : ram_rdata;
   assign parity_err = ram_perr && !addr_err;
   assign running    = (state == ST_RUN);

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Randomised self-checking bench for imem_fetch_unit.
// Reference model tracks memory contents and fetch results as plain arrays.
module tb_imem_fetch_unit;

   localparam int DW    = 32;
   localparam int DEPTH = 256;
   localparam int AW    = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          ld_we;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic          ld_done;
   logic          fetch_req;
   logic [AW-1:0] pc;
   logic          stall;
   logic [DW-1:0] instr;
   logic          instr_valid;
   logic          addr_err;
   logic          load_err;
   logic          running;
   logic          parity_err;

   always #5 clk = ~clk;

   imem_fetch_unit #(
      .DATA_W   (DW),
      .DEPTH    (DEPTH),
      .ADDR_W   (AW),
      .NOP_WORD (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ld_we       (ld_we),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_done     (ld_done),
      .fetch_req   (fetch_req),
      .pc          (pc),
      .stall       (stall),
      .instr       (instr),
      .instr_valid (instr_valid),
      .addr_err    (addr_err),
      .load_err    (load_err),
      .running     (running),
      .parity_err  (parity_err)
   );

   int errors = 0;
   int checks = 0;

   logic [31:0] m_mem  [DEPTH];
   bit          m_flip [DEPTH];
   bit          m_run, m_lerr, m_valid, m_aerr, m_perr;
   logic [31:0] m_instr;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("instr", instr, m_instr);
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("addr_err", 32'(addr_err), 32'(m_aerr));
      chk("load_err", 32'(load_err), 32'(m_lerr));
      chk("running", 32'(running), 32'(m_run));
      chk("parity_err", 32'(parity_err), 32'(m_perr));
   endtask

   task automatic model_reset();
      m_run   = 0;
      m_lerr  = 0;
      m_valid = 0;
      m_aerr  = 0;
      m_perr  = 0;
      m_instr = 32'h0;
   endtask

   task automatic model(bit we, int la, logic [31:0] ld, bit dn,
                        bit fr, int p, bit st);
      if (!m_run) begin
         if (we) begin
            if (la < DEPTH) begin
               m_mem[la]  = ld;
               m_flip[la] = 0;
            end else begin
               m_lerr = 1;
            end
         end
         if (dn) m_run = 1;
      end else begin
         if (we) m_lerr = 1;
         if (!st) begin
            m_valid = fr;
            if (fr) begin
               if (p < DEPTH) begin
                  m_instr = m_mem[p];
                  m_aerr  = 0;
                  m_perr  = m_flip[p];
               end else begin
                  m_instr = 32'h0;
                  m_aerr  = 1;
                  m_perr  = 0;
               end
            end
         end
      end
   endtask

   task automatic drive(bit we, int la, logic [31:0] ld, bit dn,
                        bit fr, int p, bit st);
      ld_we     = we;
      ld_addr   = AW'(la);
      ld_data   = ld;
      ld_done   = dn;
      fetch_req = fr;
      pc        = AW'(p);
      stall     = st;
   endtask

   // one cycle: drive at negedge, model at posedge, check at next negedge
   task automatic step(bit we, int la, logic [31:0] ld, bit dn,
                       bit fr, int p, bit st);
      drive(we, la, ld, dn, fr, p, st);
      @(posedge clk);
      model(we, la, ld, dn, fr, p, st);
      @(negedge clk);
      check_all();
   endtask

   task automatic fetch(int p);
      step(0, 0, 32'h0, 0, 1, p, 0);
   endtask

   task automatic idle();
      step(0, 0, 32'h0, 0, 0, 0, 0);
   endtask

   task automatic rand_run(int n);
      for (int i = 0; i < n; i++) begin
         bit fr, st, we;
         int p;
         fr = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 3) == 0);
         we = ($urandom_range(0, 15) == 0);
         p  = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH, 1023)
                                          : $urandom_range(0, DEPTH - 1);
         step(we, $urandom_range(0, 1023), $urandom, 0, fr, p, st);
      end
   endtask

   initial begin
      drive(0, 0, 32'h0, 0, 0, 0, 0);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < DEPTH; i++) m_flip[i] = 0;
      @(negedge clk);
      @(negedge clk);
      check_all();
      reset = 1'b1;
      @(negedge clk);

      // program load
      for (int i = 4; i < DEPTH; i++) step(1, i, $urandom, 0, 0, 0, 0);
      step(1, 0, 32'h0800_0005, 0, 0, 0, 0);
      step(1, 1, 32'h5800_0001, 0, 0, 0, 0);
      step(1, 2, 32'h0000_0000, 0, 0, 0, 0);
      // fetch ignored while loading
      fetch(0);
      fetch(1);
      // write and ld_done together
      step(1, 3, 32'hDEAD_BEEF, 1, 0, 0, 0);
      fetch(1);
      fetch(3);
      // range boundaries
      fetch(255);
      fetch(256);
      fetch(300);
      idle();
      fetch(1023);
      fetch(0);
      // write attempt in RUN
      step(1, 5, 32'h1234_5678, 0, 0, 0, 0);
      fetch(5);
      // back-to-back with stall on pc=2
      fetch(0);
      fetch(1);
      step(0, 0, 32'h0, 0, 1, 2, 1);
      step(0, 0, 32'h0, 0, 1, 2, 1);
      idle();
      fetch(2);

      rand_run(400);

      // reset with a fetch in flight
      fetch(1);
      drive(0, 0, 32'h0, 0, 1, 2, 0);
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      reset = 1'b1;
      check_all();

      // out-of-range load write, then rerun same program
      fetch(0);
      step(1, 256, 32'hFFFF_FFFF, 0, 0, 0, 0);
      step(0, 0, 32'h0, 1, 0, 0, 0);
      fetch(0);
      fetch(1);

`ifdef IMEM_PARITY_EN
      @(negedge clk);
      dut.u_ram.mem[2][0] = ~dut.u_ram.mem[2][0];
      m_mem[2][0] = ~m_mem[2][0];
      m_flip[2] = 1;
      fetch(2);
      fetch(1);
      fetch(2);
      step(0, 0, 32'h0, 0, 1, 1, 1);
      fetch(300);
`endif

      rand_run(300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
